// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types for the two-requester round-robin arbiter: state encoding,
// default payload width and a small owner-to-state helper.
package mux2_rr_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  // Map requester index (0/1) to its ownership state.
  function automatic state_t own_of(input logic who);
    return who ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mux2_w.sv
// Plain combinational 2:1 data mux: s=0 selects a, s=1 selects b.
module mux2_w #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              s,
  output logic [DATA_W-1:0] out
);

  assign out = s ? b : a;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter giving two producers access to one valid/ready consumer,
// holding grants across bursts with a per-grant fairness cap of MAX_HOLD beats.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic              out_ready,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_d;
  logic             accept;
  logic             owner;
  logic             own_req;
  logic             oth_req;

  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign accept    = out_valid & out_ready;

  // Next-state, beat counter and last-owner update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner   = (state_q == ST_OWN1);
    own_req = owner ? req1 : req0;
    oth_req = owner ? req0 : req1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = own_of(~last_q);
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          // Owner withdrew: hand straight over if the other side is waiting.
          last_d  = owner;
          cnt_d   = '0;
          state_d = oth_req ? own_of(~owner) : ST_IDLE;
        end else if (accept) begin
          if (cnt_q == CNT_MAX && oth_req) begin
            last_d  = owner;
            cnt_d   = '0;
            state_d = own_of(~owner);
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Select follows the owner and keeps its last value while idle.
  always_comb begin
    sel_d = sel;
    if (state_d == ST_OWN1) begin
      sel_d = 1'b1;
    end else if (state_d == ST_OWN0) begin
      sel_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      sel     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt0    <= (state_d == ST_OWN0);
      gnt1    <= (state_d == ST_OWN1);
      sel     <= sel_d;
    end
  end

  mux2_w #(.DATA_W(DATA_W)) u_mux (
    .a   (data0),
    .b   (data1),
    .s   (sel),
    .out (out_data)
  );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench: stimulus pushes per-cycle expectations from a behavioural
// model of the arbitration rules; a monitor pops and compares against the DUT.
module tb_mux2_rr_arbiter;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CNT_W    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0;
  logic              req1 = 1'b0;
  logic [DATA_W-1:0] data0 = '0;
  logic [DATA_W-1:0] data1 = '0;
  logic              out_ready = 1'b0;
  logic              gnt0, gnt1, sel, out_valid;
  logic [DATA_W-1:0] out_data;

  mux2_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .out_ready (out_ready),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              known;
    bit              g0;
    bit              g1;
    bit              sl;
    bit              vld;
    logic [DATA_W-1:0] dat;
    bit              in_rst;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: owner is 0 (nobody), 1 (requester 0) or 2 (requester 1);
  // beats counts accepted beats under the current grant, unbounded.
  int m_own   = 0;
  int m_beats = 0;
  bit m_last  = 1'b1;
  bit m_sel   = 1'b0;
  bit m_known = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input bit r, input bit a, input bit b,
                       input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                       input bit rdy);
    exp_t e;
    bit   rq[2];
    int   me, other;
    @(negedge clk);
    rst = r; req0 = a; req1 = b; data0 = x; data1 = y; out_ready = rdy;
    n_vec++;
    e.known  = m_known;
    e.g0     = (m_own == 1);
    e.g1     = (m_own == 2);
    e.sl     = m_sel;
    e.vld    = (m_own == 1 && a) || (m_own == 2 && b);
    e.dat    = (m_own == 2) ? y : x;
    e.in_rst = r;
    q.push_back(e);
    rq[0] = a;
    rq[1] = b;
    if (r) begin
      m_own = 0; m_beats = 0; m_last = 1'b1; m_sel = 1'b0; m_known = 1'b1;
    end else if (m_known) begin
      if (m_own == 0) begin
        m_beats = 0;
        if (a && b) m_own = m_last ? 1 : 2;
        else if (a) m_own = 1;
        else if (b) m_own = 2;
      end else begin
        me    = m_own - 1;
        other = 1 - me;
        if (!rq[me]) begin
          m_last  = me[0];
          m_beats = 0;
          m_own   = rq[other] ? other + 1 : 0;
        end else if (rdy) begin
          m_beats++;
          if (m_beats >= MAX_HOLD && rq[other]) begin
            m_last  = me[0];
            m_beats = 0;
            m_own   = other + 1;
          end
        end
      end
      if (m_own == 2) m_sel = 1'b1;
      else if (m_own == 1) m_sel = 1'b0;
    end
  endtask

  // Monitor: compares mid-cycle, after inputs have settled.
  int wait_beats[2] = '{0, 0};
  initial begin
    exp_t e;
    bit   rq[2];
    bit   gn[2];
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.known) begin
          chk("gnt0", 32'(gnt0), 32'(e.g0));
          chk("gnt1", 32'(gnt1), 32'(e.g1));
          chk("sel", 32'(sel), 32'(e.sl));
          chk("out_valid", 32'(out_valid), 32'(e.vld));
          if (e.vld) chk("out_data", 32'(out_data), 32'(e.dat));
          chk("grant_onehot", 32'(gnt0 & gnt1), 32'(0));
        end
        rq[0] = req0; rq[1] = req1;
        gn[0] = gnt0; gn[1] = gnt1;
        for (int i = 0; i < 2; i++) begin
          if (e.in_rst || !rq[i] || gn[i]) begin
            wait_beats[i] = 0;
          end else if (out_valid && out_ready) begin
            wait_beats[i]++;
            chk("fair_wait", 32'(wait_beats[i] > MAX_HOLD), 32'(0));
          end
        end
      end
    end
  end

  initial begin
    logic [DATA_W-1:0] x, y;
    bit a, b, r, rdy;
    apply(1, 0, 0, 8'h00, 8'h00, 0);
    apply(1, 0, 0, 8'h00, 8'h00, 0);
    // Single requester streaming a fixed payload.
    for (int i = 0; i < 6; i++) apply(0, 1, 0, 8'hA5, 8'h3C, 1);
    apply(0, 0, 0, 8'h00, 8'h00, 1);
    apply(1, 0, 0, 8'h00, 8'h00, 0);
    // Both requesting with a ready consumer: alternating bursts of MAX_HOLD.
    for (int i = 0; i < 20; i++) apply(0, 1, 1, 8'($urandom), 8'($urandom), 1);
    // Consumer stalled: owner and count frozen.
    for (int i = 0; i < 10; i++) apply(0, 1, 1, 8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 1, 8'($urandom), 8'($urandom), 1);
    // Reset in the middle of a burst, then a tie.
    apply(0, 1, 1, 8'h11, 8'h22, 1);
    apply(0, 1, 1, 8'h11, 8'h22, 1);
    apply(1, 1, 1, 8'h11, 8'h22, 1);
    for (int i = 0; i < 4; i++) apply(0, 1, 1, 8'h33, 8'h44, 1);
    // Requester 1 owns with requester 0 waiting, then drops early.
    apply(1, 0, 0, 8'h00, 8'h00, 0);
    apply(0, 0, 1, 8'h55, 8'h66, 1);
    apply(0, 1, 1, 8'h55, 8'h66, 1);
    apply(0, 1, 1, 8'h55, 8'h67, 1);
    apply(0, 1, 0, 8'h56, 8'h00, 1);
    apply(0, 1, 0, 8'h57, 8'h00, 1);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 10000; i++) begin
      r   = ($urandom_range(0, 999) == 0);
      a   = ($urandom_range(0, 3) != 0);
      b   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      x   = 8'($urandom);
      y   = 8'($urandom);
      apply(r, a, b, x, y, rdy);
    end
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 8'h00, 8'h00, 1);
    @(negedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
